// File: rtl/qmul_stream_ctrl_pkg.sv
// Shared encodings for the quaternion-multiplier stream sequencer:
// FSM states, operand/result counts and operand word positions.
package qmul_stream_ctrl_pkg;

  localparam int unsigned N_OPERANDS = 8;
  localparam int unsigned N_RESULTS  = 4;
  localparam int unsigned OpIdxW     = 3;
  localparam int unsigned WaitCntW   = 8;

  // Operand word positions in the input stream
  localparam int unsigned IdxA1 = 0;
  localparam int unsigned IdxB1 = 1;
  localparam int unsigned IdxC1 = 2;
  localparam int unsigned IdxD1 = 3;
  localparam int unsigned IdxA2 = 4;
  localparam int unsigned IdxB2 = 5;
  localparam int unsigned IdxC2 = 6;
  localparam int unsigned IdxD2 = 7;

  typedef enum logic [2:0] {
    StCollect,
    StLoad,
    StCompute,
    StWait,
    StEmit
  } state_e;

endpackage

// File: rtl/qmul_stream_ctrl.sv
// Host-side sequencer for one quaternion multiplier: collects eight operand words,
// pulses load/compute, waits for the result and streams r1..r4 back out.
module qmul_stream_ctrl
  import qmul_stream_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [15:0]      s_data,
  output logic             m_load,
  output logic             m_compute,
  output logic [15:0]      m_a1,
  output logic [15:0]      m_b1,
  output logic [15:0]      m_c1,
  output logic [15:0]      m_d1,
  output logic [15:0]      m_a2,
  output logic [15:0]      m_b2,
  output logic [15:0]      m_c2,
  output logic [15:0]      m_d2,
  input  logic             m_valid,
  input  logic [31:0]      m_r1,
  input  logic [31:0]      m_r2,
  input  logic [31:0]      m_r3,
  input  logic [31:0]      m_r4,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [31:0]      o_data,
  output logic             o_last,
  output logic             err,
  output logic [CNT_W-1:0] job_cnt
);

  localparam logic [WaitCntW-1:0] TimeoutCnt = WaitCntW'(TIMEOUT);
  localparam logic [OpIdxW-1:0]   LastOpIdx  = OpIdxW'(N_OPERANDS - 1);
  localparam logic [1:0]          LastResIdx = 2'(N_RESULTS - 1);
  localparam logic [CNT_W-1:0]    CntOne     = CNT_W'(1);

  state_e state_q, state_d;

  logic [OpIdxW-1:0]   idx_q, idx_d;
  logic [WaitCntW-1:0] wait_q, wait_d;
  logic [15:0]         opnd_q [N_OPERANDS];
  logic [15:0]         opnd_d [N_OPERANDS];
  logic [31:0]         res_q  [N_RESULTS];
  logic [31:0]         res_d  [N_RESULTS];
  logic                err_q, err_d;
  logic [CNT_W-1:0]    job_cnt_q, job_cnt_d;

  logic s_acc, o_acc, emit_last, wait_expired;

  assign s_acc        = (state_q == StCollect) && s_valid;
  assign o_acc        = (state_q == StEmit) && o_ready;
  assign emit_last    = (idx_q[1:0] == LastResIdx);
  assign wait_expired = (wait_q == TimeoutCnt);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StCollect;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; m_valid takes priority over an expiring timeout
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StCollect: if (s_acc && (idx_q == LastOpIdx)) state_d = StLoad;
      StLoad:    state_d = StCompute;
      StCompute: state_d = StWait;
      StWait: begin
        if (m_valid) begin
          state_d = StEmit;
        end else if (wait_expired) begin
          state_d = StCollect;
        end
      end
      StEmit:    if (o_acc && emit_last) state_d = StCollect;
      default:   state_d = StCollect;
    endcase
  end

  // Outputs decoded from the current state
  always_comb begin
    s_ready   = 1'b0;
    m_load    = 1'b0;
    m_compute = 1'b0;
    o_valid   = 1'b0;
    o_last    = 1'b0;
    o_data    = '0;
    unique case (state_q)
      StCollect: s_ready = 1'b1;
      StLoad:    m_load = 1'b1;
      StCompute: m_compute = 1'b1;
      StEmit: begin
        o_valid = 1'b1;
        o_last  = emit_last;
        o_data  = res_q[idx_q[1:0]];
      end
      default: ;
    endcase
  end

  // Datapath next-state: operand file, result buffer, counters, flags
  always_comb begin
    idx_d     = idx_q;
    wait_d    = wait_q;
    opnd_d    = opnd_q;
    res_d     = res_q;
    err_d     = err_q;
    job_cnt_d = job_cnt_q;
    unique case (state_q)
      StCollect: begin
        if (s_acc) begin
          opnd_d[idx_q] = s_data;
          idx_d         = (idx_q == LastOpIdx) ? '0 : idx_q + 3'd1;
        end
      end
      StCompute: wait_d = '0;
      StWait: begin
        if (m_valid) begin
          res_d[0] = m_r1;
          res_d[1] = m_r2;
          res_d[2] = m_r3;
          res_d[3] = m_r4;
          idx_d    = '0;
        end else if (wait_expired) begin
          err_d = 1'b1;
          idx_d = '0;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      StEmit: begin
        if (o_acc) begin
          if (emit_last) begin
            idx_d     = '0;
            job_cnt_d = job_cnt_q + CntOne;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q     <= '0;
      wait_q    <= '0;
      opnd_q    <= '{default: '0};
      res_q     <= '{default: '0};
      err_q     <= 1'b0;
      job_cnt_q <= '0;
    end else begin
      idx_q     <= idx_d;
      wait_q    <= wait_d;
      opnd_q    <= opnd_d;
      res_q     <= res_d;
      err_q     <= err_d;
      job_cnt_q <= job_cnt_d;
    end
  end

  assign m_a1    = opnd_q[IdxA1];
  assign m_b1    = opnd_q[IdxB1];
  assign m_c1    = opnd_q[IdxC1];
  assign m_d1    = opnd_q[IdxD1];
  assign m_a2    = opnd_q[IdxA2];
  assign m_b2    = opnd_q[IdxB2];
  assign m_c2    = opnd_q[IdxC2];
  assign m_d2    = opnd_q[IdxD2];
  assign err     = err_q;
  assign job_cnt = job_cnt_q;

endmodule

// File: tb/tb_qmul_stream_ctrl.sv
// Bench for qmul_stream_ctrl: directed jobs against a behavioural stock multiplier,
// expected words queued at issue and checked by an independent output monitor.
module tb_qmul_stream_ctrl;

  typedef struct {
    logic [31:0] d;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [15:0] s_data = '0;
  logic        m_load, m_compute;
  logic [15:0] m_a1, m_b1, m_c1, m_d1, m_a2, m_b2, m_c2, m_d2;
  logic        m_valid;
  logic [31:0] m_r1, m_r2, m_r3, m_r4;
  logic        o_valid;
  logic        o_ready = 1'b1;
  logic [31:0] o_data;
  logic        o_last;
  logic        err;
  logic [15:0] job_cnt;

  int   n_cmp = 0;
  int   n_err = 0;
  int   load_n = 0;
  int   comp_n = 0;
  int   overlap_n = 0;
  exp_t exp_q[$];

  logic       mul_en = 1'b1;
  logic       rdy_toggle = 1'b0;
  logic [3:0] rdy_pat = 4'b1001;
  int         rdy_ph = 0;

  qmul_stream_ctrl #(.TIMEOUT(15), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_load(m_load), .m_compute(m_compute),
    .m_a1(m_a1), .m_b1(m_b1), .m_c1(m_c1), .m_d1(m_d1),
    .m_a2(m_a2), .m_b2(m_b2), .m_c2(m_c2), .m_d2(m_d2),
    .m_valid(m_valid), .m_r1(m_r1), .m_r2(m_r2), .m_r3(m_r3), .m_r4(m_r4),
    .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data), .o_last(o_last),
    .err(err), .job_cnt(job_cnt)
  );

  always #5 clk = ~clk;

  // Stock multiplier: latch on load, result valid one cycle after compute
  logic signed [15:0] la1, lb1, lc1, ld1, la2, lb2, lc2, ld2;
  logic signed [31:0] sr1, sr2, sr3, sr4;
  logic               mv;
  always @(posedge clk) begin
    if (rst) begin
      mv <= 1'b0;
    end else begin
      if (m_load) begin
        la1 <= m_a1; lb1 <= m_b1; lc1 <= m_c1; ld1 <= m_d1;
        la2 <= m_a2; lb2 <= m_b2; lc2 <= m_c2; ld2 <= m_d2;
      end
      mv <= m_compute & mul_en;
      if (m_compute) begin
        sr1 <= la1 * la2 - lb1 * lb2 - lc1 * lc2 - ld1 * ld2;
        sr2 <= la1 * lb2 + lb1 * la2 + lc1 * ld2 - ld1 * lc2;
        sr3 <= la1 * lc2 - lb1 * ld2 + lc1 * la2 + ld1 * lb2;
        sr4 <= la1 * ld2 + lb1 * lc2 - lc1 * lb2 + ld1 * la2;
      end
    end
  end
  assign m_valid = mv;
  assign m_r1 = sr1;
  assign m_r2 = sr2;
  assign m_r3 = sr3;
  assign m_r4 = sr4;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // o_ready driven shortly after each rising edge
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rdy_toggle) begin
        o_ready = rdy_pat[rdy_ph];
        rdy_ph  = (rdy_ph + 1) % 4;
      end else begin
        o_ready = 1'b1;
      end
    end
  end

  // Monitor: compares every presented word to the queue head, pops on handshake
  always @(negedge clk) begin
    if (!rst) begin
      if (m_load) load_n++;
      if (m_compute) comp_n++;
      if (m_load && m_compute) overlap_n++;
      if (o_valid) begin
        check("s_ready_in_emit", {31'd0, s_ready}, 32'd0);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_o_valid: got %h expected no output", o_data);
        end else begin
          check("o_data", o_data, exp_q[0].d);
          check("o_last", {31'd0, o_last}, {31'd0, exp_q[0].last});
          if (o_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  function automatic logic [7:0][15:0] ops8(input logic [15:0] a1, b1, c1, d1,
                                                  input logic [15:0] a2, b2, c2, d2);
    ops8[0] = a1; ops8[1] = b1; ops8[2] = c1; ops8[3] = d1;
    ops8[4] = a2; ops8[5] = b2; ops8[6] = c2; ops8[7] = d2;
  endfunction

  function automatic logic [3:0][31:0] res4(input logic [31:0] r1, r2, r3, r4);
    res4[0] = r1; res4[1] = r2; res4[2] = r3; res4[3] = r4;
  endfunction

  // Returns #1 after the accepting rising edge
  task automatic send_word(input logic [15:0] w);
    int guard = 0;
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = w;
    while (!s_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) begin
      n_cmp++;
      n_err++;
      $display("FAIL s_ready_wait: got s_ready=0 for 100 cycles expected 1");
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic send_job(input logic [7:0][15:0] ops, input logic [3:0][31:0] res,
                          input int gap, input bit push);
    if (push) begin
      for (int i = 0; i < 4; i++) exp_q.push_back('{d: res[i], last: (i == 3)});
    end
    for (int i = 0; i < 8; i++) begin
      if (i != 0) repeat (gap) @(negedge clk);
      send_word(ops[i]);
    end
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    do begin
      @(posedge clk);
      #3;
      n++;
    end while (!(s_ready && exp_q.size() == 0) && n < 300);
    if (n >= 300) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_idle: got busy after 300 cycles expected idle", tag);
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  logic [7:0][15:0] job1, job2, job3, jobb, jobc;
  logic [3:0][31:0] exp1, exp3, expb, expc;
  int l0, c0;

  initial begin
    job1 = ops8(16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8);
    exp1 = res4(32'hFFFF_FFC4, 32'h0000_000C, 32'h0000_001E, 32'h0000_0018);
    job3 = ops8(16'hFFFF, 16'd0, 16'd0, 16'd0, 16'h8000, 16'd0, 16'd0, 16'd0);
    exp3 = res4(32'h0000_8000, 32'd0, 32'd0, 32'd0);
    jobb = ops8(16'd2, 16'd0, 16'd0, 16'd0, 16'd3, 16'd4, 16'd5, 16'd6);
    expb = res4(32'd6, 32'd8, 32'd10, 32'd12);
    jobc = ops8(16'd0, 16'd1, 16'd0, 16'd0, 16'd0, 16'd1, 16'd0, 16'd0);
    expc = res4(32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0);
    job2 = job1;

    // Reset state
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_s_ready", {31'd0, s_ready}, 32'd1);
    check("rst_o_valid", {31'd0, o_valid}, 32'd0);
    check("rst_m_load", {31'd0, m_load | m_compute}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_job_cnt", {16'd0, job_cnt}, 32'd0);
    check("rst_m_a1", {16'd0, m_a1}, 32'd0);

    // 1: basic job, cycle-accurate latency
    send_job(job1, exp1, 0, 1'b1);
    check("t1_m_load_T1", {31'd0, m_load}, 32'd1);
    check("t1_s_ready_T1", {31'd0, s_ready}, 32'd0);
    check("t1_m_d2", {16'd0, m_d2}, 32'd8);
    @(posedge clk); #1;
    check("t1_m_compute_T2", {30'd0, m_compute, m_load}, 32'd2);
    @(posedge clk); #1;
    check("t1_o_valid_T3", {31'd0, o_valid}, 32'd0);
    @(posedge clk); #1;
    check("t1_o_valid_T4", {31'd0, o_valid}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("t1_o_last_T7", {31'd0, o_last}, 32'd1);
    @(posedge clk); #1;
    check("t1_s_ready_T8", {31'd0, s_ready}, 32'd1);
    check("t1_job_cnt", {16'd0, job_cnt}, 32'd1);

    // 2: output back-pressure
    rdy_toggle = 1'b1;
    rdy_ph = 0;
    send_job(job2, exp1, 0, 1'b1);
    wait_done("t2");
    rdy_toggle = 1'b0;
    check("t2_job_cnt", {16'd0, job_cnt}, 32'd2);

    // 3: extreme operands with input gaps
    send_job(job3, exp3, 2, 1'b1);
    wait_done("t3");
    check("t3_job_cnt", {16'd0, job_cnt}, 32'd3);

    // 4: multiplier never answers
    mul_en = 1'b0;
    send_job(job1, exp1, 0, 1'b0);
    repeat (17) @(posedge clk);
    #1;
    check("t4_err_T18", {31'd0, err}, 32'd0);
    @(posedge clk); #1;
    check("t4_err_T19", {31'd0, err}, 32'd1);
    check("t4_s_ready", {31'd0, s_ready}, 32'd1);
    check("t4_o_valid", {31'd0, o_valid}, 32'd0);
    check("t4_job_cnt", {16'd0, job_cnt}, 32'd3);
    mul_en = 1'b1;
    send_job(jobb, expb, 0, 1'b1);
    wait_done("t4b");
    check("t4b_job_cnt", {16'd0, job_cnt}, 32'd4);
    check("t4b_err_sticky", {31'd0, err}, 32'd1);

    // 5: reset mid-collect
    for (int i = 0; i < 5; i++) send_word(jobb[i]);
    reset_dut();
    #1;
    check("t5_err_cleared", {31'd0, err}, 32'd0);
    check("t5_job_cnt_clr", {16'd0, job_cnt}, 32'd0);
    send_job(job1, exp1, 0, 1'b1);
    wait_done("t5");
    check("t5_job_cnt", {16'd0, job_cnt}, 32'd1);

    // 6: three jobs back-to-back
    reset_dut();
    l0 = load_n;
    c0 = comp_n;
    send_job(job1, exp1, 0, 1'b1);
    send_job(jobb, expb, 0, 1'b1);
    send_job(jobc, expc, 0, 1'b1);
    wait_done("t6");
    check("t6_job_cnt", {16'd0, job_cnt}, 32'd3);
    check("t6_loads", 32'(load_n - l0), 32'd3);
    check("t6_computes", 32'(comp_n - c0), 32'd3);
    check("t6_overlap", 32'(overlap_n), 32'd0);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish within 200us");
    $fatal(1, "watchdog expired");
  end

endmodule
